// File: rtl/ifu_fetch_queue_if.sv
// Instruction-memory request/acknowledge bus between the fetch queue and memory.
// The fetch side holds imem_req as a level until memory returns a one-cycle
// imem_ack; imem_rdata is valid in the same cycle as imem_ack.
interface ifu_fetch_queue_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: issues one instruction-memory request at a time from
// pc_addr and buffers returned words in a QDEPTH-entry FIFO for decode.
// A redirect flushes the queue; a request already in flight is drained and its
// data dropped.
// Optional feature: define FETCH_ALIGN_CHK_EN to turn a misaligned pc_addr into
// a queued address-error entry (inst_adel=1) rather than a memory request.
module ifu_fetch_queue #(
   parameter int QDEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        pc_addr,
   output logic               pc_enable,
   ifu_fetch_queue_if.master  imem,
   input  logic               redirect,
   input  logic               id_ready,
   output logic               inst_valid,
   output logic [31:0]        inst,
   output logic [31:0]        inst_pc,
   output logic               inst_adel
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t        r_state;
   logic          r_imem_req;
   logic [31:0]   r_imem_addr;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [31:0]   r_q_inst [QDEPTH];
   logic [31:0]   r_q_pc   [QDEPTH];
`ifdef FETCH_ALIGN_CHK_EN
   logic          r_q_adel [QDEPTH];
`endif

   logic          w_full;
   logic          w_misalign;
   logic          w_idle_ok;
   logic          w_issue;
   logic          w_adel_push;
   logic          w_ack_push;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_push_inst;
   logic [31:0]   w_push_pc;

`ifdef FETCH_ALIGN_CHK_EN
   assign w_misalign = (pc_addr[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_full      = (r_count == FULL_CNT);
   assign w_idle_ok   = (r_state == IDLE) && !w_full && !redirect;
   assign w_issue     = w_idle_ok && !w_misalign;
   assign w_adel_push = w_idle_ok && w_misalign;
   // Ack data is only accepted while a live request is outstanding.
   assign w_ack_push  = (r_state == WAIT) && imem.imem_ack && !redirect;
   assign w_push      = w_ack_push || w_adel_push;
   assign w_pop       = inst_valid && id_ready && !redirect;
   assign w_push_inst = w_adel_push ? 32'h0 : imem.imem_rdata;
   assign w_push_pc   = w_adel_push ? pc_addr : r_imem_addr;

   // The PC must not move while reset is asserted, even if redirect is high.
   assign pc_enable = reset && (w_issue || redirect);

   assign imem.imem_req  = r_imem_req;
   assign imem.imem_addr = r_imem_addr;

   // Request FSM: at most one outstanding memory request.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_imem_req  <= 1'b0;
         r_imem_addr <= 32'h0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_imem_addr <= pc_addr & 32'hFFFF_FFFC;
                  r_imem_req  <= 1'b1;
                  r_state     <= WAIT;
               end
            end
            WAIT: begin
               if (imem.imem_ack) begin
                  r_imem_req <= 1'b0;
                  r_state    <= IDLE;
               end else if (redirect) begin
                  r_state <= DROP;
               end
            end
            DROP: begin
               if (imem.imem_ack) begin
                  r_imem_req <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_imem_req <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   // Queue occupancy and pointers; redirect flushes ahead of any push or pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (redirect) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Queue storage write port.
   // NOTE: storage is not reset; entries are only visible through a non-zero count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_inst[r_wr_ptr] <= w_push_inst;
         r_q_pc[r_wr_ptr]   <= w_push_pc;
`ifdef FETCH_ALIGN_CHK_EN
         r_q_adel[r_wr_ptr] <= w_adel_push;
`endif
      end
   end

   assign inst_valid = (r_count != '0);
   assign inst       = inst_valid ? r_q_inst[r_rd_ptr] : 32'h0;
   assign inst_pc    = inst_valid ? r_q_pc[r_rd_ptr]   : 32'h0;
`ifdef FETCH_ALIGN_CHK_EN
   assign inst_adel  = inst_valid ? r_q_adel[r_rd_ptr] : 1'b0;
`else
   assign inst_adel  = 1'b0;
`endif

endmodule
